// File: rtl/tm1638_serial_driver_if.sv
// TM1638 3-wire serial bus (STB/CLK/DIO with split DIO drive/enable/sample).
// master = the driver side, slave = the board (or a board model).
interface tm1638_serial_driver_if;
  logic sio_stb;
  logic sio_clk;
  logic sio_data_out;
  logic sio_data_oe;
  logic sio_data_in;

  modport master (
    output sio_stb,
    output sio_clk,
    output sio_data_out,
    output sio_data_oe,
    input  sio_data_in
  );

  modport slave (
    input  sio_stb,
    input  sio_clk,
    input  sio_data_out,
    input  sio_data_oe,
    output sio_data_in
  );
endinterface

// File: rtl/tm1638_serial_driver.sv
// Continuously refreshes a TM1638 LED&KEY board from multiplexed digit/segment inputs.
// Optional key scanning (READ_CMD/READ_WAIT/READ_DATA) is enabled by defining TM1638_KEY_SCAN_EN.
module tm1638_serial_driver #(
  parameter int clk_mhz = 50,
  parameter int w_digit = 8,
  parameter int w_keys  = 8,
  parameter int w_seg   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [w_seg-1:0]       hgfedcba,
  input  logic [w_digit-1:0]     digit,
  input  logic [7:0]             ledr,
  output logic [w_keys-1:0]      keys,
  output logic                   frame_done,
  tm1638_serial_driver_if.master sio
);

  localparam int half_period = (clk_mhz / 2 > 1) ? clk_mhz / 2 : 1;
  localparam int w_div       = $clog2(half_period + 1);
  localparam logic [w_div-1:0] div_last = w_div'(half_period - 1);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CMD_MODE  = 4'd1;
  localparam logic [3:0] ST_GAP       = 4'd2;
  localparam logic [3:0] ST_ADDR_DATA = 4'd3;
  localparam logic [3:0] ST_DISP_CTRL = 4'd4;
  localparam logic [3:0] ST_READ_CMD  = 4'd5;
  localparam logic [3:0] ST_READ_WAIT = 4'd6;
  localparam logic [3:0] ST_READ_DATA = 4'd7;
  localparam logic [3:0] ST_FRAME_END = 4'd8;

  // Sub-phase of a byte-transfer state: STB fall, CLK low + DIO, CLK high, STB rise.
  localparam logic [1:0] PH_START = 2'd0;
  localparam logic [1:0] PH_LO    = 2'd1;
  localparam logic [1:0] PH_HI    = 2'd2;
  localparam logic [1:0] PH_END   = 2'd3;

  logic [w_div-1:0] div_q, div_d;
  logic             tick;
  logic [3:0]       state_q, state_d, after_gap_q, after_gap_d, follow_state;
  logic [1:0]       ph_q, ph_d;
  logic [2:0]       bit_q, bit_d;
  logic [4:0]       byte_q, byte_d, byte_last;
  logic             stb_q, stb_d, sclk_q, sclk_d, dout_q, dout_d, oe_q, oe_d;
  logic [w_keys-1:0] keys_q, keys_d, key_decode;
  logic             frame_done_q, frame_done_d;
  logic             snap_en;
  logic [7:0]       tx_byte;

  logic [w_seg-1:0] seg_q       [w_digit];
  logic [7:0]       frame_bytes [16];
  logic [7:0]       snap_q      [16];

  assign tick = (div_q == div_last);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Chip address map: position p = w_digit-1-i, segments at 2p, LED at 2p+1 bit 0.
  for (genvar a = 0; a < 16; a++) begin : g_map
    if (a / 2 < w_digit) begin : g_on
      if (a % 2 == 0) begin : g_seg
        assign frame_bytes[a] = 8'(seg_q[w_digit - 1 - a / 2]);
      end else begin : g_led
        assign frame_bytes[a] = {7'b0, ledr[w_digit - 1 - a / 2]};
      end
    end else begin : g_off
      assign frame_bytes[a] = 8'h00;
    end
  end

  always_comb begin
    tx_byte = 8'h40;
    case (state_q)
      ST_ADDR_DATA: tx_byte = (byte_q == 5'd0) ? 8'hC0 : snap_q[4'(byte_q - 5'd1)];
      ST_DISP_CTRL: tx_byte = 8'h8F;
      ST_READ_CMD:  tx_byte = 8'h42;
      default:      tx_byte = 8'h40;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_ADDR_DATA: byte_last = 5'd16;
      ST_READ_DATA: byte_last = 5'd3;
      default:      byte_last = 5'd0;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_CMD_MODE:  follow_state = ST_ADDR_DATA;
      ST_ADDR_DATA: follow_state = ST_DISP_CTRL;
`ifdef TM1638_KEY_SCAN_EN
      ST_DISP_CTRL: follow_state = ST_READ_CMD;
`endif
      default:      follow_state = ST_FRAME_END;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    after_gap_d  = after_gap_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    stb_d        = stb_q;
    sclk_d       = sclk_q;
    dout_d       = dout_q;
    oe_d         = oe_q;
    keys_d       = keys_q;
    frame_done_d = 1'b0;
    snap_en      = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD_MODE;
          ph_d    = PH_START;
        end
        ST_GAP: begin
          state_d = after_gap_q;
          ph_d    = PH_START;
          bit_d   = 3'd0;
          byte_d  = 5'd0;
          snap_en = (after_gap_q == ST_ADDR_DATA);
        end
`ifdef TM1638_KEY_SCAN_EN
        ST_READ_WAIT: begin
          // CLK has been high since the last command bit; release DIO for the chip.
          oe_d    = 1'b0;
          state_d = ST_READ_DATA;
          ph_d    = PH_LO;
          bit_d   = 3'd0;
          byte_d  = 5'd0;
        end
`endif
        ST_FRAME_END: begin
          keys_d       = key_decode;
          frame_done_d = 1'b1;
          state_d      = ST_CMD_MODE;
          ph_d         = PH_START;
        end
        default: begin
          case (ph_q)
            PH_START: begin
              stb_d = 1'b0;
              oe_d  = 1'b1;
              ph_d  = PH_LO;
            end
            PH_LO: begin
              sclk_d = 1'b0;
              if (state_q != ST_READ_DATA) dout_d = tx_byte[bit_q];
              ph_d = PH_HI;
            end
            PH_HI: begin
              sclk_d = 1'b1;
              if (bit_q == 3'd7 && byte_q == byte_last) begin
                if (state_q == ST_READ_CMD) state_d = ST_READ_WAIT;
                else                        ph_d    = PH_END;
              end else begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) byte_d = byte_q + 5'd1;
                ph_d = PH_LO;
              end
            end
            default: begin
              stb_d       = 1'b1;
              oe_d        = 1'b0;
              dout_d      = 1'b1;
              state_d     = ST_GAP;
              after_gap_d = follow_state;
            end
          endcase
        end
      endcase
    end
  end

`ifdef TM1638_KEY_SCAN_EN
  // Only bits 0 and 4 of each read byte carry keys: pos_q[{bit[2], byte}] = position.
  logic [7:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (tick && state_q == ST_READ_DATA && ph_q == PH_HI && bit_q[1:0] == 2'b00)
      pos_d[{bit_q[2], byte_q[1:0]}] = sio.sio_data_in;
  end

  for (genvar p = 0; p < w_keys; p++) begin : g_keys
    assign key_decode[w_keys - 1 - p] = pos_q[p];
  end

  always_ff @(posedge clk) begin
    if (!rst) pos_q <= '0;
    else      pos_q <= pos_d;
  end
`else
  assign key_decode = '0;
`endif

  // NOTE: state uses non-blocking assignments; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q        <= '0;
      state_q      <= ST_IDLE;
      ph_q         <= PH_START;
      after_gap_q  <= ST_CMD_MODE;
      bit_q        <= 3'd0;
      byte_q       <= 5'd0;
      stb_q        <= 1'b1;
      sclk_q       <= 1'b1;
      dout_q       <= 1'b1;
      oe_q         <= 1'b0;
      keys_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      state_q      <= state_d;
      ph_q         <= ph_d;
      after_gap_q  <= after_gap_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      stb_q        <= stb_d;
      sclk_q       <= sclk_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
      keys_q       <= keys_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q <= '{default: '0};
    end else begin
      for (int i = 0; i < w_digit; i++) begin
        if (digit[i]) seg_q[i] <= hgfedcba;
      end
    end
  end

  // NOTE: the snapshot is storage only, always loaded before it is sent, so it has no reset.
  always_ff @(posedge clk) begin
    if (rst && snap_en) snap_q <= frame_bytes;
  end

  assign sio.sio_stb      = stb_q;
  assign sio.sio_clk      = sclk_q;
  assign sio.sio_data_out = dout_q;
  assign sio.sio_data_oe  = oe_q;
  assign keys             = keys_q;
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_tm1638_serial_driver.sv
// Directed bench for tm1638_serial_driver with a behavioural TM1638 model on the serial bus.
module tb_tm1638_serial_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] hgfedcba = 8'h00;
  logic [7:0] digit = 8'h00;
  logic [7:0] ledr = 8'h00;
  logic [7:0] keys;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  tm1638_serial_driver_if sif ();

  tm1638_serial_driver #(
    .clk_mhz (4),
    .w_digit (8),
    .w_keys  (8),
    .w_seg   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hgfedcba   (hgfedcba),
    .digit      (digit),
    .ledr       (ledr),
    .keys       (keys),
    .frame_done (frame_done),
    .sio        (sif)
  );

  always #5 clk = ~clk;

`ifdef TM1638_KEY_SCAN_EN
  localparam int EXP_LEN = 20;
`else
  localparam int EXP_LEN = 19;
`endif

  // ---------------- board model ----------------
  logic [7:0] key_bytes [4];
  logic [7:0] cur_frame [$];
  logic [7:0] last_frame [$];
  logic [7:0] shreg;
  logic [7:0] kb;
  logic       prev_sclk = 1'b1;
  logic       rd_mode = 1'b0;
  int         bit_cnt = 0;
  int         rd_bit = 0;
  int         txn_bytes = 0;
  int         frames_seen = 0;
  int         oe_low_cnt = 0;
  logic [7:0] keys_prev = 8'h00;
  logic [7:0] keys_at_done = 8'h00;
  logic [7:0] keys_before_done = 8'h00;

  initial begin
    for (int i = 0; i < 4; i++) key_bytes[i] = 8'h00;
  end

  always @(negedge clk) begin
    if (!rst || sif.sio_stb) begin
      if (!rst) cur_frame.delete();
      bit_cnt = 0;
      rd_mode = 1'b0;
      rd_bit = 0;
      txn_bytes = 0;
      sif.sio_data_in = 1'b1;
    end else begin
      if (!sif.sio_data_oe) oe_low_cnt++;
      if (!prev_sclk && sif.sio_clk && sif.sio_data_oe && !rd_mode) begin
        shreg = {sif.sio_data_out, shreg[7:1]};
        bit_cnt++;
        if (bit_cnt == 8) begin
          cur_frame.push_back(shreg);
          if (txn_bytes == 0 && shreg == 8'h42) rd_mode = 1'b1;
          txn_bytes++;
          bit_cnt = 0;
        end
      end
      if (prev_sclk && !sif.sio_clk && rd_mode && rd_bit < 32) begin
        kb = key_bytes[rd_bit / 8];
        sif.sio_data_in = kb[rd_bit % 8];
        rd_bit++;
      end
    end
    if (frame_done) begin
      last_frame = cur_frame;
      cur_frame.delete();
      frames_seen++;
      keys_at_done = keys;
      keys_before_done = keys_prev;
    end
    keys_prev = keys;
    prev_sclk = sif.sio_clk;
  end

  // ---------------- expected frame ----------------
  logic [7:0] exp_data [16];

  function automatic logic [7:0] exp_byte(input int k);
    if (k == 0)  return 8'h40;
    if (k == 1)  return 8'hC0;
    if (k < 18)  return exp_data[k - 2];
    if (k == 18) return 8'h8F;
    return 8'h42;
  endfunction

  function automatic logic [7:0] act_byte(input int k);
    if (k < last_frame.size()) return last_frame[k];
    return 8'hxx;
  endfunction

  // Index of first differing byte of last_frame, or -1 when it matches exactly.
  function automatic int frame_mismatch();
    for (int k = 0; k < EXP_LEN; k++) begin
      if (k >= last_frame.size()) return k;
      if (last_frame[k] !== exp_byte(k)) return k;
    end
    if (last_frame.size() != EXP_LEN) return EXP_LEN;
    return -1;
  endfunction

  task automatic clear_exp();
    for (int a = 0; a < 16; a++) exp_data[a] = 8'h00;
  endtask

  task automatic wait_frames(input int n);
    int start;
    start = frames_seen;
    for (int c = 0; c < 3000 * n; c++) begin
      @(negedge clk);
      if (frames_seen >= start + n) return;
    end
    checks++;
    errors++;
    $display("FAIL frame_timeout: saw %0d frames, wanted %0d", frames_seen - start, n);
  endtask

  task automatic wait_bytes(input int n);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (cur_frame.size() >= n) return;
    end
    checks++;
    errors++;
    $display("FAIL byte_timeout: saw %0d bytes, wanted %0d", cur_frame.size(), n);
  endtask

  task automatic write_digits(input logic [7:0] d, input logic [7:0] seg);
    @(negedge clk);
    digit = d;
    hgfedcba = seg;
    @(negedge clk);
    digit = 8'h00;
    hgfedcba = 8'hFF;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int idx;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sif.sio_stb !== 1'b1) begin errors++; $display("FAIL reset_stb: got %b want 1", sif.sio_stb); end
    checks++; if (sif.sio_clk !== 1'b1) begin errors++; $display("FAIL reset_clk: got %b want 1", sif.sio_clk); end
    checks++; if (sif.sio_data_out !== 1'b1) begin errors++; $display("FAIL reset_dout: got %b want 1", sif.sio_data_out); end
    checks++; if (sif.sio_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", sif.sio_data_oe); end
    checks++; if (keys !== 8'h00) begin errors++; $display("FAIL reset_keys: got %h want 00", keys); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    rst = 1'b1;
    wait_frames(1);
    clear_exp();
    idx = frame_mismatch();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL reset_frame: byte %0d got %h want %h (len %0d want %0d)",
               idx, act_byte(idx), exp_byte(idx), last_frame.size(), EXP_LEN);
    end
  endtask

  task automatic test_digit_write();
    int idx;
    write_digits(8'b0000_0001, 8'h3F);
    wait_frames(2);
    exp_data[14] = 8'h3F;
    idx = frame_mismatch();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL digit_frame: byte %0d got %h want %h (len %0d want %0d)",
               idx, act_byte(idx), exp_byte(idx), last_frame.size(), EXP_LEN);
    end
  endtask

  task automatic test_led();
    int idx;
    @(negedge clk);
    ledr = 8'b1000_0000;
    wait_frames(2);
    exp_data[1] = 8'h01;
    idx = frame_mismatch();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL led_frame: byte %0d got %h want %h (len %0d want %0d)",
               idx, act_byte(idx), exp_byte(idx), last_frame.size(), EXP_LEN);
    end
    checks++; if (act_byte(3) !== 8'h01) begin errors++; $display("FAIL led_addr1: got %h want 01", act_byte(3)); end
    checks++; if (act_byte(17) !== 8'h00) begin errors++; $display("FAIL led_addr15: got %h want 00", act_byte(17)); end
    checks++; if (act_byte(18) !== 8'h8F) begin errors++; $display("FAIL disp_ctrl: got %h want 8f", act_byte(18)); end
  endtask

  task automatic test_multi_digit();
    int idx;
    write_digits(8'b1010_0000, 8'h5B);
    wait_frames(2);
    exp_data[0] = 8'h5B;
    exp_data[4] = 8'h5B;
    idx = frame_mismatch();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL multi_digit_frame: byte %0d got %h want %h (len %0d want %0d)",
               idx, act_byte(idx), exp_byte(idx), last_frame.size(), EXP_LEN);
    end
  endtask

  task automatic test_snapshot();
    int idx;
    wait_frames(1);
    wait_bytes(4);
    write_digits(8'b0000_0001, 8'h06);
    wait_frames(1);
    idx = frame_mismatch();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL snapshot_same: byte %0d got %h want %h", idx, act_byte(idx), exp_byte(idx));
    end
    wait_frames(1);
    exp_data[14] = 8'h06;
    idx = frame_mismatch();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL snapshot_next: byte %0d got %h want %h", idx, act_byte(idx), exp_byte(idx));
    end
  endtask

  task automatic test_keys();
`ifdef TM1638_KEY_SCAN_EN
    wait_frames(1);
    wait_bytes(4);
    key_bytes[0] = 8'h01;
    key_bytes[1] = 8'h00;
    key_bytes[2] = 8'h00;
    key_bytes[3] = 8'h10;
    wait_frames(1);
    // byte0 bit0 -> position 0 -> keys[7]; byte3 bit4 -> position 7 -> keys[0]
    checks++; if (keys_at_done !== 8'b1000_0001) begin errors++; $display("FAIL keys_at_done: got %b want 10000001", keys_at_done); end
    checks++; if (keys_before_done !== 8'h00) begin errors++; $display("FAIL keys_before_done: got %b want 00000000", keys_before_done); end
    checks++; if (act_byte(19) !== 8'h42) begin errors++; $display("FAIL read_cmd: got %h want 42", act_byte(19)); end
    checks++; if (oe_low_cnt == 0) begin errors++; $display("FAIL read_release: oe low cycles %0d want >0", oe_low_cnt); end
`else
    wait_frames(1);
    checks++; if (keys_at_done !== 8'h00) begin errors++; $display("FAIL keys_tied: got %b want 00000000", keys_at_done); end
    checks++; if (last_frame.size() != 19) begin errors++; $display("FAIL no_read_len: got %0d bytes want 19", last_frame.size()); end
    checks++; if (act_byte(18) !== 8'h8F) begin errors++; $display("FAIL last_byte: got %h want 8f", act_byte(18)); end
    checks++; if (oe_low_cnt != 0) begin errors++; $display("FAIL oe_low_stb_low: got %0d cycles want 0", oe_low_cnt); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    int idx;
    wait_frames(1);
    wait_bytes(5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sif.sio_stb !== 1'b1) begin errors++; $display("FAIL mid_reset_stb: got %b want 1", sif.sio_stb); end
    checks++; if (sif.sio_clk !== 1'b1) begin errors++; $display("FAIL mid_reset_clk: got %b want 1", sif.sio_clk); end
    checks++; if (sif.sio_data_oe !== 1'b0) begin errors++; $display("FAIL mid_reset_oe: got %b want 0", sif.sio_data_oe); end
    checks++; if (keys !== 8'h00) begin errors++; $display("FAIL mid_reset_keys: got %h want 00", keys); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    wait_frames(1);
    clear_exp();
    exp_data[1] = 8'h01;
    checks++; if (act_byte(0) !== 8'h40) begin errors++; $display("FAIL post_reset_first: got %h want 40", act_byte(0)); end
    idx = frame_mismatch();
    checks++;
    if (idx >= 0) begin
      errors++;
      $display("FAIL post_reset_frame: byte %0d got %h want %h (len %0d want %0d)",
               idx, act_byte(idx), exp_byte(idx), last_frame.size(), EXP_LEN);
    end
  endtask

  initial begin
    clear_exp();
    test_reset();
    test_digit_write();
    test_led();
    test_multi_digit();
    test_snapshot();
    test_keys();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
